// File: rtl/lcd_stream_ctrl.sv
// Character-stream front end for the character-LCD driver: buffers chars and home
// commands, tracks the row/column cursor and issues one flow-controlled write per char.
module lcd_stream_ctrl #(
  parameter int ROWS       = 2,
  parameter int COLS       = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int WRAP       = 1,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = $clog2(COLS)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          valid_i,
  input  logic [7:0]    char,
  output logic          ready_o,
  input  logic          start_update,
  input  logic          lcd_busy,
  output logic          lcd_we,
  output logic [RW-1:0] lcd_row,
  output logic [CW-1:0] lcd_col,
  output logic [7:0]    lcd_char,
  output logic          update,
  output logic          frame_full,
  output logic          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam bit NOWRAP = (WRAP == 0);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GAP  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [8:0]    mem_r [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   rd_ptr_r;
  logic          home_pend_r;
  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic [8:0]    push_data_s;
  logic          pop_s;
  logic [8:0]    head_s;
  logic [1:0]    state_r;
  logic [RW-1:0] row_r;
  logic [CW-1:0] col_r;
  logic          last_done_r;
  logic          wrote_r;
  logic          at_last_s;

  // The extra pointer bit distinguishes full from empty when the indices match.
  assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty_s   = (wr_ptr_r == rd_ptr_r);
  assign ready_o   = !full_s && !start_update && !home_pend_r;
  assign head_s    = mem_r[rd_ptr_r[AW-1:0]];
  assign at_last_s = (row_r == ROW_LAST) && (col_r == COL_LAST);

  // Push select: a home command (new or pending) wins over an offered char.
  always_comb begin
    push_s      = 1'b0;
    push_data_s = 9'h000;
    if ((start_update || home_pend_r) && !full_s) begin
      push_s      = 1'b1;
      push_data_s = 9'h100;
    end else if (valid_i && ready_o) begin
      push_s      = 1'b1;
      push_data_s = {1'b0, char};
    end else begin
      push_s      = 1'b0;
    end
  end

  // Pop whenever IDLE can consume the head entry this cycle.
  always_comb begin
    pop_s = 1'b0;
    if (state_r == S_IDLE && !empty_s) begin
      pop_s = head_s[8] || (NOWRAP && last_done_r) || !lcd_busy;
    end else begin
      pop_s = 1'b0;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_data_s;
    end
  end

  // FIFO pointers and the deferred home command.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_r    <= {(AW+1){1'b0}};
      rd_ptr_r    <= {(AW+1){1'b0}};
      home_pend_r <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      if (pop_s)  rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      if (start_update && full_s) begin
        home_pend_r <= 1'b1;
      end else if (home_pend_r && !full_s) begin
        home_pend_r <= 1'b0;
      end
    end
  end

  // Write sequencer: IDLE issues, GAP advances the cursor, WAIT follows lcd_busy.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r     <= S_IDLE;
      row_r       <= {RW{1'b0}};
      col_r       <= {CW{1'b0}};
      last_done_r <= 1'b0;
      wrote_r     <= 1'b0;
      lcd_we      <= 1'b0;
      lcd_row     <= {RW{1'b0}};
      lcd_col     <= {CW{1'b0}};
      lcd_char    <= 8'h00;
      update      <= 1'b0;
      frame_full  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      lcd_we     <= 1'b0;
      update     <= 1'b0;
      frame_full <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (!empty_s) begin
            if (head_s[8]) begin
              row_r       <= {RW{1'b0}};
              col_r       <= {CW{1'b0}};
              overflow    <= 1'b0;
              last_done_r <= 1'b0;
            end else if (NOWRAP && last_done_r) begin
              overflow <= 1'b1;
            end else if (!lcd_busy) begin
              lcd_we   <= 1'b1;
              lcd_row  <= row_r;
              lcd_col  <= col_r;
              lcd_char <= head_s[7:0];
              wrote_r  <= 1'b1;
              state_r  <= S_GAP;
            end
          end else if (wrote_r) begin
            update  <= 1'b1;
            wrote_r <= 1'b0;
          end
        end
        S_GAP: begin
          frame_full <= at_last_s;
          // Without wrap the cursor parks on the last cell and later chars are dropped.
          if (NOWRAP && at_last_s) begin
            last_done_r <= 1'b1;
          end else if (col_r == COL_LAST) begin
            col_r <= {CW{1'b0}};
            row_r <= (row_r == ROW_LAST) ? {RW{1'b0}} : row_r + RW'(1);
          end else begin
            col_r <= col_r + CW'(1);
          end
          state_r <= S_WAIT;
        end
        S_WAIT: begin
          if (!lcd_busy) state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_stream_ctrl.sv
// Self-checking bench for lcd_stream_ctrl: a wrapping and a non-wrapping instance,
// table-driven char vectors plus sequences, writes checked against a scoreboard queue.
module tb_lcd_stream_ctrl;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RST;
  logic       sel;
  logic       valid_i;
  logic [7:0] char_i;
  logic       start_update;
  logic       lcd_busy;
  logic       busy_force;
  int         busy_cnt;

  logic       ready1, we1, upd1, ff1, ovf1;
  logic [0:0] row1;
  logic [3:0] col1;
  logic [7:0] char1;
  logic       ready0, we0, upd0, ff0, ovf0;
  logic [0:0] row0;
  logic [3:0] col0;
  logic [7:0] char0;

  lcd_stream_ctrl #(.ROWS(2), .COLS(16), .FIFO_DEPTH(4), .WRAP(1)) u_wrap (
    .CLK(CLK), .RST(RST), .valid_i(valid_i & ~sel), .char(char_i), .ready_o(ready1),
    .start_update(start_update & ~sel), .lcd_busy(lcd_busy), .lcd_we(we1), .lcd_row(row1),
    .lcd_col(col1), .lcd_char(char1), .update(upd1), .frame_full(ff1), .overflow(ovf1)
  );

  lcd_stream_ctrl #(.ROWS(2), .COLS(16), .FIFO_DEPTH(4), .WRAP(0)) u_nowrap (
    .CLK(CLK), .RST(RST), .valid_i(valid_i & sel), .char(char_i), .ready_o(ready0),
    .start_update(start_update & sel), .lcd_busy(lcd_busy), .lcd_we(we0), .lcd_row(row0),
    .lcd_col(col0), .lcd_char(char0), .update(upd0), .frame_full(ff0), .overflow(ovf0)
  );

  logic       rdy_s, we_s, upd_s, ff_s, ovf_s;
  logic [0:0] row_s;
  logic [3:0] col_s;
  logic [7:0] chr_s;
  assign rdy_s = sel ? ready0 : ready1;
  assign we_s  = sel ? we0    : we1;
  assign upd_s = sel ? upd0   : upd1;
  assign ff_s  = sel ? ff0    : ff1;
  assign ovf_s = sel ? ovf0   : ovf1;
  assign row_s = sel ? row0   : row1;
  assign col_s = sel ? col0   : col1;
  assign chr_s = sel ? char0  : char1;

  typedef struct packed {
    logic [0:0] row;
    logic [3:0] col;
    logic [7:0] ch;
  } exp_t;

  typedef struct {
    int         hm;   // 0: plain, 1: home before, 2: home coincident with valid
    logic [7:0] ch;
    logic [0:0] r;
    logic [3:0] c;
  } vec_t;

  exp_t       sb[$];
  vec_t       tbl[8];
  int         checks, errors;
  int         acc_cnt, we_cnt, upd_cnt, upd_at_we, ff_cnt;
  logic [4:0] last_pos, ff_pos;
  int         base, ffb;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic home();
    @(negedge CLK);
    start_update = 1'b1;
    @(posedge CLK);
    #1;
    start_update = 1'b0;
  endtask

  task automatic send(input int hm, input logic [7:0] ch, input bit expw,
                      input logic [0:0] r, input logic [3:0] c);
    int   n;
    exp_t e;
    n = 0;
    if (hm == 1) home();
    @(negedge CLK);
    valid_i = 1'b1;
    char_i  = ch;
    if (hm == 2) begin
      start_update = 1'b1;
      #1;
      chk("ready_low_with_home", rdy_s, 1'b0);
      @(posedge CLK);
      #1;
      start_update = 1'b0;
      @(negedge CLK);
    end
    while (!rdy_s && n < 300) begin
      @(negedge CLK);
      n++;
    end
    chk("accept", rdy_s, 1'b1);
    if (rdy_s) begin
      acc_cnt++;
      if (expw) begin
        e.row = r;
        e.col = c;
        e.ch  = ch;
        sb.push_back(e);
      end
    end
    @(posedge CLK);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
    repeat (10) @(negedge CLK);
  endtask

  initial begin
    exp_t e;
    checks = 0; errors = 0; acc_cnt = 0; we_cnt = 0; upd_cnt = 0; upd_at_we = 0; ff_cnt = 0;
    last_pos = 5'd0; ff_pos = 5'd0;
    RST = 1'b0; sel = 1'b0; valid_i = 1'b0; char_i = 8'h00; start_update = 1'b0;
    busy_force = 1'b0; busy_cnt = 0; lcd_busy = 1'b0;

    tbl[0] = '{0, 8'h41, 1'b0, 4'd0};
    tbl[1] = '{0, 8'h42, 1'b0, 4'd1};
    tbl[2] = '{0, 8'h43, 1'b0, 4'd2};
    tbl[3] = '{0, 8'h41, 1'b0, 4'd3};
    tbl[4] = '{0, 8'h42, 1'b0, 4'd4};
    tbl[5] = '{1, 8'h43, 1'b0, 4'd0};
    tbl[6] = '{2, 8'h44, 1'b0, 4'd0};
    tbl[7] = '{0, 8'h45, 1'b0, 4'd1};

    // Monitor: scoreboard compare on every write, pulse bookkeeping, driver busy model.
    fork
      forever begin
        @(negedge CLK);
        if (RST) begin
          if (we_s) begin
            we_cnt++;
            last_pos = {row_s, col_s};
            busy_cnt = 3;
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL spurious_write: got char %0h at (%0d,%0d) expected no write",
                       chr_s, row_s, col_s);
            end else begin
              e = sb.pop_front();
              chk("write_row", row_s, e.row);
              chk("write_col", col_s, e.col);
              chk("write_char", chr_s, e.ch);
            end
          end
          if (upd_s) begin
            upd_cnt++;
            upd_at_we = we_cnt;
          end
          if (ff_s) begin
            ff_cnt++;
            ff_pos = last_pos;
          end
        end
        lcd_busy = busy_force | (busy_cnt != 0);
        if (busy_cnt != 0) busy_cnt--;
      end
    join_none

    #12;
    chk("rst_ready", ready1, 1'b1);
    chk("rst_ready_nowrap", ready0, 1'b1);
    chk("rst_we", we1, 1'b0);
    chk("rst_update", upd1, 1'b0);
    chk("rst_frame_full", ff1, 1'b0);
    chk("rst_overflow", ovf1, 1'b0);
    chk("rst_pos", {row1, col1}, 5'd0);
    chk("rst_char", char1, 8'h00);
    @(negedge CLK);
    RST = 1'b1;

    for (int i = 0; i < 8; i++) begin
      send(tbl[i].hm, tbl[i].ch, 1'b1, tbl[i].r, tbl[i].c);
      if (i == 2) begin
        wait_drain();
        chk("update_count", upd_cnt, 1);
        chk("update_after_writes", upd_at_we, 3);
      end
    end
    wait_drain();

    // Busy held: four chars fill the FIFO, nothing is written until busy falls.
    home();
    wait_drain();
    base = we_cnt;
    acc_cnt = 0;
    busy_force = 1'b1;
    fork
      begin
        for (int k = 0; k < 6; k++) send(0, 8'(8'h61 + k), 1'b1, 1'b0, 4'(k));
      end
      begin
        repeat (20) @(negedge CLK);
        chk("busy_accepted", acc_cnt, 4);
        chk("busy_ready_low", rdy_s, 1'b0);
        chk("busy_no_write", we_cnt - base, 0);
        busy_force = 1'b0;
      end
    join
    wait_drain();
    chk("busy_total_writes", we_cnt - base, 6);

    // Wrapping screen: 33 chars after home.
    home();
    ffb = ff_cnt;
    for (int i = 0; i < 33; i++) send(0, 8'(8'h20 + i), 1'b1, 1'((i / 16) % 2), 4'(i % 16));
    wait_drain();
    chk("frame_full_count", ff_cnt - ffb, 1);
    chk("frame_full_pos", ff_pos, {1'b1, 4'hF});
    chk("wrap_overflow", ovf1, 1'b0);

    // Non-wrapping screen: 33rd char dropped and flagged.
    @(negedge CLK);
    sel = 1'b1;
    home();
    base = we_cnt;
    for (int i = 0; i < 33; i++) send(0, 8'(8'h30 + i), (i < 32), 1'((i / 16) % 2), 4'(i % 16));
    wait_drain();
    chk("nowrap_writes", we_cnt - base, 32);
    chk("overflow_set", ovf_s, 1'b1);
    home();
    repeat (4) @(negedge CLK);
    chk("overflow_cleared", ovf_s, 1'b0);
    send(0, 8'h5A, 1'b1, 1'b0, 4'd0);
    wait_drain();
    @(negedge CLK);
    sel = 1'b0;

    // Reset while waiting on the driver.
    home();
    send(0, 8'h51, 1'b1, 1'b0, 4'd0);
    send(0, 8'h52, 1'b1, 1'b0, 4'd1);
    begin
      int n;
      n = 0;
      while (sb.size() != 0 && n < 300) begin
        @(negedge CLK);
        n++;
      end
      chk("pre_reset_pending", sb.size(), 0);
    end
    busy_force = 1'b1;
    repeat (3) @(negedge CLK);
    #2;
    RST = 1'b0;
    #1;
    chk("async_rst_char", char1, 8'h00);
    chk("async_rst_col", col1, 4'd0);
    chk("async_rst_we", we1, 1'b0);
    chk("async_rst_ready", ready1, 1'b1);
    sb.delete();
    busy_force = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    send(0, 8'h53, 1'b1, 1'b0, 4'd0);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
